// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, datapath selects.
// Imported by the controller, the instruction classifier and the datapath blocks.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WB_ALU = 4'd5,
        S_WB_MEM = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_HALT   = 4'd9
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] ALU_LUI  = 2'd3;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MEM  = 2'd1;
    localparam logic [1:0] M2R_PC4  = 2'd2;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_JR   = 2'd3;

    typedef struct packed {
        logic isAddu;
        logic isSubu;
        logic isOri;
        logic isLui;
        logic isLw;
        logic isSw;
        logic isBeq;
        logic isJ;
        logic isJal;
        logic isJr;
    } instrClassT;

    // Flags are one-hot, so any set bit means a supported instruction.
    function automatic logic isLegal(input instrClassT c);
        return |c;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath signal bundle. The illegal flag exists only when
// MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       PCWr;
    logic       IRWr;
    logic       RegWr;
    logic       MemWr;
    logic       MemRd;
    logic       ExtOp;
    logic       ALUSrc;
    logic [1:0] ALUOp;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] NPCOp;
    logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    modport master (
        input  op, funct, zero, mem_ready,
        output PCWr, IRWr, RegWr, MemWr, MemRd, ExtOp, ALUSrc,
        output ALUOp, RegDst, MemtoReg, NPCOp,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        output illegal,
`endif
        output state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  PCWr, IRWr, RegWr, MemWr, MemRd, ExtOp, ALUSrc,
        input  ALUOp, RegDst, MemtoReg, NPCOp,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        input  state
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational classifier: op/funct to one-hot instruction-class flags.
// Unsupported encodings produce all-zero flags.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output instrClassT cls
);

    logic rType;

    assign rType = (op == OP_RTYPE);

    always_comb begin
        cls        = '0;
        cls.isAddu = rType && (funct == FN_ADDU);
        cls.isSubu = rType && (funct == FN_SUBU);
        cls.isJr   = rType && (funct == FN_JR);
        cls.isOri  = (op == OP_ORI);
        cls.isLui  = (op == OP_LUI);
        cls.isLw   = (op == OP_LW);
        cls.isSw   = (op == OP_SW);
        cls.isBeq  = (op == OP_BEQ);
        cls.isJ    = (op == OP_J);
        cls.isJal  = (op == OP_JAL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FSM sequencing fetch/decode/execute/memory/writeback.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported instructions in S_HALT.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    stateT      stateReg;
    stateT      nextState;
    logic [5:0] opLat;
    logic [5:0] functLat;
    logic [5:0] opSel;
    logic [5:0] functSel;
    instrClassT cls;
    logic       rType;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stateReg <= S_FETCH;
        else       stateReg <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opLat    <= '0;
            functLat <= '0;
        end else if (stateReg == S_DECODE) begin
            opLat    <= bus.op;
            functLat <= bus.funct;
        end
    end

    // Decode sees the live IR only in S_DECODE; afterwards the IR may change under us.
    assign opSel    = (stateReg == S_DECODE) ? bus.op    : opLat;
    assign functSel = (stateReg == S_DECODE) ? bus.funct : functLat;

    mc_decode uDecode (
        .op    (opSel),
        .funct (functSel),
        .cls   (cls)
    );

    assign rType = cls.isAddu | cls.isSubu;

    always_comb begin
        nextState = S_FETCH;
        case (stateReg)
            S_FETCH:  nextState = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (cls.isJ || cls.isJal || cls.isJr) nextState = S_JUMP;
                else if (cls.isBeq)                   nextState = S_BRANCH;
                else if (isLegal(cls))                nextState = S_EXE;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                else                                  nextState = S_HALT;
`endif
            end
            S_EXE: begin
                if (cls.isLw)      nextState = S_MEMRD;
                else if (cls.isSw) nextState = S_MEMWR;
                else               nextState = S_WB_ALU;
            end
            S_MEMRD:  nextState = bus.mem_ready ? S_WB_MEM : S_MEMRD;
            S_MEMWR:  nextState = bus.mem_ready ? S_FETCH  : S_MEMWR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_HALT:   nextState = S_HALT;
`endif
            default:  nextState = S_FETCH;
        endcase
    end

    always_comb begin
        bus.PCWr     = 1'b0;
        bus.IRWr     = 1'b0;
        bus.RegWr    = 1'b0;
        bus.MemWr    = 1'b0;
        bus.MemRd    = 1'b0;
        bus.ExtOp    = 1'b1;
        bus.ALUSrc   = 1'b0;
        bus.ALUOp    = ALU_ADD;
        bus.RegDst   = DST_RT;
        bus.MemtoReg = M2R_ALU;
        bus.NPCOp    = NPC_PC4;
        if (reset) begin
            bus.ExtOp = 1'b0;
        end else begin
            case (stateReg)
                S_FETCH: begin
                    bus.MemRd = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IRWr  = 1'b1;
                        bus.PCWr  = 1'b1;
                        bus.NPCOp = NPC_PC4;
                    end
                end
                S_EXE: begin
                    if (cls.isSubu) begin
                        bus.ALUOp = ALU_SUB;
                    end else if (cls.isOri) begin
                        bus.ALUOp  = ALU_OR;
                        bus.ALUSrc = 1'b1;
                        bus.ExtOp  = 1'b0;
                    end else if (cls.isLui) begin
                        bus.ALUOp  = ALU_LUI;
                        bus.ALUSrc = 1'b1;
                        bus.ExtOp  = 1'b0;
                    end else if (cls.isLw || cls.isSw) begin
                        bus.ALUSrc = 1'b1;
                    end
                end
                S_MEMRD:  bus.MemRd = 1'b1;
                S_MEMWR:  bus.MemWr = 1'b1;
                S_WB_ALU: begin
                    bus.RegWr  = 1'b1;
                    bus.RegDst = rType ? DST_RD : DST_RT;
                end
                S_WB_MEM: begin
                    bus.RegWr    = 1'b1;
                    bus.MemtoReg = M2R_MEM;
                end
                S_BRANCH: begin
                    bus.ALUOp = ALU_SUB;
                    bus.NPCOp = NPC_BR;
                    bus.PCWr  = bus.zero;
                end
                S_JUMP: begin
                    bus.PCWr  = 1'b1;
                    bus.NPCOp = cls.isJr ? NPC_JR : NPC_J;
                    if (cls.isJal) begin
                        bus.RegWr    = 1'b1;
                        bus.RegDst   = DST_RA;
                        bus.MemtoReg = M2R_PC4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state = stateReg;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal = (stateReg == S_HALT);
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed cases plus randomized instruction stream
// with random memory wait states, checked cycle by cycle against an instruction-level model.
module tb_mc_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcWr;
        logic       irWr;
        logic       regWr;
        logic       memWr;
        logic       memRd;
        logic       extOp;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic [1:0] regDst;
        logic [1:0] memtoReg;
        logic [1:0] npcOp;
        logic       ill;
    } obsT;

    int checkCnt = 0;
    int passCnt  = 0;

    logic [5:0] opPool [12] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                                6'h04, 6'h02, 6'h03, 6'h00, 6'h3F, 6'h00};
    logic [5:0] fnPool [12] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h25};

    // Instruction kinds: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jal 9 jr 10 unsupported
    function automatic int kindOf(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   return 0;
                    6'h23:   return 1;
                    6'h08:   return 9;
                    default: return 10;
                endcase
            end
            6'h0D:   return 2;
            6'h0F:   return 3;
            6'h23:   return 4;
            6'h2B:   return 5;
            6'h04:   return 6;
            6'h02:   return 7;
            6'h03:   return 8;
            default: return 10;
        endcase
    endfunction

    function automatic obsT idle(input logic [3:0] st);
        obsT o = '0;
        o.st    = st;
        o.extOp = 1'b1;
        return o;
    endfunction

    function automatic obsT sample();
        obsT o;
        o.st       = bus.state;
        o.pcWr     = bus.PCWr;
        o.irWr     = bus.IRWr;
        o.regWr    = bus.RegWr;
        o.memWr    = bus.MemWr;
        o.memRd    = bus.MemRd;
        o.extOp    = bus.ExtOp;
        o.aluSrc   = bus.ALUSrc;
        o.aluOp    = bus.ALUOp;
        o.regDst   = bus.RegDst;
        o.memtoReg = bus.MemtoReg;
        o.npcOp    = bus.NPCOp;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        o.ill      = bus.illegal;
`else
        o.ill      = 1'b0;
`endif
        return o;
    endfunction

    task automatic check(input obsT exp, input string tag);
        obsT got;
        got = sample();
        checkCnt++;
        assert (got === exp) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    // One cycle: drive inputs at the falling edge, check combinational outputs 1 ns later.
    task automatic step(input logic mr, input logic z, input logic [5:0] o,
                        input logic [5:0] f, input obsT exp, input string tag);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.op        = o;
        bus.funct     = f;
        #1;
        check(exp, tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b1;
        bus.op        = r6();
        #1;
        check('0, "reset_asserted");
        @(negedge clk);
        #1;
        check('0, "reset_held");
        bus.mem_ready = 1'b0;
        reset         = 1'b0;
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] funct, input int fetchWait,
                            input int memWait, input logic zeroVal, input bit abortMem);
        int  k;
        obsT e;
        k = kindOf(op, funct);

        repeat (fetchWait) begin
            e = idle(4'd0); e.memRd = 1'b1;
            step(1'b0, rb(), r6(), r6(), e, "fetch_wait");
        end
        e = idle(4'd0); e.memRd = 1'b1; e.irWr = 1'b1; e.pcWr = 1'b1;
        step(1'b1, rb(), r6(), r6(), e, "fetch");
        e = idle(4'd1);
        step(rb(), rb(), op, funct, e, "decode");

        if (k == 10) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            repeat (3) begin
                e = idle(4'd9); e.ill = 1'b1;
                step(1'b1, rb(), r6(), r6(), e, "halt");
            end
            doReset();
`endif
            return;
        end

        if (k == 6) begin
            e = idle(4'd7); e.aluOp = 2'd1; e.npcOp = 2'd1; e.pcWr = zeroVal;
            step(rb(), zeroVal, r6(), r6(), e, "branch");
            return;
        end

        if (k >= 7) begin
            e = idle(4'd8); e.pcWr = 1'b1; e.npcOp = (k == 9) ? 2'd3 : 2'd2;
            if (k == 8) begin
                e.regWr = 1'b1; e.regDst = 2'd2; e.memtoReg = 2'd2;
            end
            step(rb(), rb(), r6(), r6(), e, "jump");
            return;
        end

        e = idle(4'd2);
        e.aluOp  = (k == 1) ? 2'd1 : (k == 2) ? 2'd2 : (k == 3) ? 2'd3 : 2'd0;
        e.aluSrc = (k >= 2);
        e.extOp  = !(k == 2 || k == 3);
        step(rb(), rb(), r6(), r6(), e, "exe");

        if (k == 4) begin
            e = idle(4'd3); e.memRd = 1'b1;
            repeat (memWait) step(1'b0, rb(), r6(), r6(), e, "memrd_wait");
            step(1'b1, rb(), r6(), r6(), e, "memrd");
            e = idle(4'd6); e.regWr = 1'b1; e.memtoReg = 2'd1;
            step(rb(), rb(), r6(), r6(), e, "wb_mem");
        end else if (k == 5) begin
            e = idle(4'd4); e.memWr = 1'b1;
            if (abortMem) begin
                step(1'b0, rb(), r6(), r6(), e, "memwr_wait");
                doReset();
                return;
            end
            repeat (memWait) step(1'b0, rb(), r6(), r6(), e, "memwr_wait");
            step(1'b1, rb(), r6(), r6(), e, "memwr");
        end else begin
            e = idle(4'd5); e.regWr = 1'b1; e.regDst = (k <= 1) ? 2'd1 : 2'd0;
            step(rb(), rb(), r6(), r6(), e, "wb_alu");
        end
    endtask

    initial begin
        bus.op        = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        #1;
        check('0, "reset_init");
        bus.mem_ready = 1'b0;
        reset         = 1'b0;

        runInstr(6'h0D, r6(),  0, 0, 1'b0, 1'b0);   // ori
        runInstr(6'h23, r6(),  0, 2, 1'b0, 1'b0);   // lw, two memory waits
        runInstr(6'h04, r6(),  0, 0, 1'b1, 1'b0);   // beq taken
        runInstr(6'h04, r6(),  0, 0, 1'b0, 1'b0);   // beq not taken
        runInstr(6'h03, r6(),  0, 0, 1'b0, 1'b0);   // jal
        runInstr(6'h00, 6'h08, 0, 0, 1'b0, 1'b0);   // jr
        runInstr(6'h00, 6'h21, 1, 0, 1'b0, 1'b0);   // addu
        runInstr(6'h00, 6'h23, 0, 0, 1'b0, 1'b0);   // subu
        runInstr(6'h0F, r6(),  0, 0, 1'b0, 1'b0);   // lui
        runInstr(6'h02, r6(),  2, 0, 1'b0, 1'b0);   // j
        runInstr(6'h2B, r6(),  0, 1, 1'b0, 1'b0);   // sw, one memory wait
        runInstr(6'h2B, r6(),  0, 0, 1'b0, 1'b1);   // sw aborted by reset in S_MEMWR
        runInstr(6'h0D, r6(),  0, 0, 1'b0, 1'b0);
        runInstr(6'h3F, r6(),  0, 0, 1'b0, 1'b0);   // unsupported opcode
        runInstr(6'h00, 6'h25, 0, 0, 1'b0, 1'b0);   // unsupported funct
        runInstr(6'h0D, r6(),  0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int         idx;
            logic [5:0] op;
            logic [5:0] fn;
            idx = int'($urandom_range(0, 11));
            op  = opPool[idx];
            fn  = (op == 6'h00) ? fnPool[idx] : r6();
            runInstr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb(),
                     ($urandom_range(0, 7) == 0));
        end
        runInstr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
